// File: rtl/quad_encoder_gen_pkg.sv
// Shared types and constants for the quadrature encoder generator.
// Phase tables are indexed by the position within a detent: entry 0 is the rest state 00.
package quad_encoder_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } qe_state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // {a,b} per phase; right has A leading B, left has B leading A.
    localparam logic [3:0][1:0] PHASE_RIGHT = {2'b01, 2'b11, 2'b10, 2'b00};
    localparam logic [3:0][1:0] PHASE_LEFT  = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [1:0] phase_ab(input logic dir, input logic [1:0] idx);
        return (dir == DIR_LEFT) ? PHASE_LEFT[idx] : PHASE_RIGHT[idx];
    endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Command and output bundle of the quadrature encoder generator.
// Handshake: a command is taken on a rising clk edge where cmd_valid and cmd_ready are both 1;
// cmd_dir/cmd_steps are sampled on that edge only. cmd_valid while cmd_ready=0 is ignored, not queued.
interface quad_encoder_gen_if #(
    parameter int STEPS_W = 16,
    parameter int POS_W   = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [STEPS_W-1:0] cmd_steps;
    logic               cmd_abort;
    logic               a;
    logic               b;
    logic               busy;
    logic               done;
    logic [POS_W-1:0]   pos;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_abort,
        input  cmd_ready, a, b, busy, done, pos
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_abort,
        output cmd_ready, a, b, busy, done, pos
    );

endinterface

// File: rtl/quad_tick_div.sv
// Step-rate divider: tick is high for one cycle every DIV cycles while clr is low.
// The count restarts from zero whenever clr is asserted, so the first tick lands DIV cycles after clr drops.
module quad_tick_div #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [23:0] LAST = 24'(DIV - 1);

    logic [23:0] cnt;

    assign tick = !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 24'd1;
        end
    end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B pattern generator: emits cmd_steps detents in the commanded direction,
// paced by quad_tick_div, and tracks a signed detent position.
module quad_encoder_gen
    import quad_encoder_gen_pkg::*;
#(
    parameter int unsigned STEP_DIV = 50000,
    parameter int          STEPS_W  = 16,
    parameter int          POS_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    quad_encoder_gen_if.slave    bus,
    output qe_state_e            dbg_state
);

    qe_state_e          state;
    logic [1:0]         phase;
    logic [1:0]         nxt_phase;
    logic               dir_q;
    logic [STEPS_W-1:0] remaining;
    logic               abort_pend;
    logic [1:0]         ab_q;
    logic [POS_W-1:0]   pos_q;
    logic               div_clr;
    logic               tick;

    assign div_clr   = (state != RUN);
    assign nxt_phase = phase + 2'd1;

    quad_tick_div #(.DIV(STEP_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= 2'd0;
            dir_q      <= DIR_RIGHT;
            remaining  <= '0;
            abort_pend <= 1'b0;
            ab_q       <= 2'b00;
            pos_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    phase      <= 2'd0;
                    abort_pend <= 1'b0;
                    ab_q       <= 2'b00;
                    if (bus.cmd_valid) begin
                        dir_q     <= bus.cmd_dir;
                        remaining <= bus.cmd_steps;
                        state     <= (bus.cmd_steps == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (bus.cmd_abort) begin
                        abort_pend <= 1'b1;
                    end
                    // At a detent boundary an abort or an exhausted count wins over a pending tick.
                    if (phase == 2'd0 && (remaining == '0 || abort_pend || bus.cmd_abort)) begin
                        state <= DONE;
                    end else if (tick) begin
                        phase <= nxt_phase;
                        ab_q  <= phase_ab(dir_q, nxt_phase);
                        if (phase == 2'd3) begin
                            remaining <= remaining - 1'b1;
                            pos_q     <= (dir_q == DIR_LEFT) ? pos_q - 1'b1 : pos_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    phase <= 2'd0;
                    ab_q  <= 2'b00;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.a         = ab_q[1];
    assign bus.b         = ab_q[0];
    assign bus.pos       = pos_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: scoreboarded A/B edges and done pulses, abort and reset corners,
// plus a narrow-width instance for position wrap and full-range step counts.
module tb_quad_encoder_gen;
  import quad_encoder_gen_pkg::*;

  localparam int STEP_DIV = 4;
  localparam int W        = 34;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quad_encoder_gen_if #(.STEPS_W(16), .POS_W(16)) qif ();
  quad_encoder_gen_if #(.STEPS_W(8),  .POS_W(8))  qw ();
  qe_state_e dbg_state;
  qe_state_e dbg_state_w;

  quad_encoder_gen #(.STEP_DIV(STEP_DIV), .STEPS_W(16), .POS_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (qif),
    .dbg_state (dbg_state)
  );

  quad_encoder_gen #(.STEP_DIV(2), .STEPS_W(8), .POS_W(8)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (qw),
    .dbg_state (dbg_state_w)
  );

  logic [1:0]   right_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0]   left_tab  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [W-1:0] exp_q [$];
  logic [47:0]  done_q [$];
  logic [15:0]  exp_pos = '0;
  logic [7:0]   exp_w = '0;
  int           model_det = 0;
  int           dec_det = 0;
  logic [1:0]   prev_ab = 2'b00;
  logic [1:0]   prev_dec = 2'b00;
  logic [1:0]   ab_now;

  assign ab_now = {qif.a, qif.b};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every a/b change and every done pulse must match the head of its queue
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ab <= ab_now;
    end else begin
      if (ab_now != prev_ab) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_edge", {62'd0, ab_now}, {62'd0, prev_ab});
        end else begin
          check_eq("edge_ab", {62'd0, ab_now}, {62'd0, exp_q[0][1:0]});
          check_eq("edge_cyc", cyc, {32'd0, exp_q[0][33:2]});
          exp_q.delete(0);
        end
      end
      prev_ab <= ab_now;
      if (qif.done) begin
        if (done_q.size() == 0) begin
          check_eq("extra_done", qif.done, 1'b0);
        end else begin
          check_eq("done_cyc", cyc, {32'd0, done_q[0][47:16]});
          check_eq("done_pos", qif.pos, done_q[0][15:0]);
          check_eq("done_busy", qif.busy, 1'b1);
          done_q.delete(0);
        end
      end
    end
  end

  // independent detent decoder on the raw a/b lines
  always @(negedge clk) begin
    if (prev_dec == 2'b01 && ab_now == 2'b00) dec_det <= dec_det + 1;
    else if (prev_dec == 2'b10 && ab_now == 2'b00) dec_det <= dec_det - 1;
    prev_dec <= ab_now;
  end

  // abort_off: cycles after the accept edge at which cmd_abort is driven for one cycle (-1 = never)
  task automatic run_cmd(input logic dir, input int steps, input int abort_off);
    int t0, s, m, det, dcyc, lim;
    logic [1:0] ab;
    det = steps;
    s = 0;
    if (abort_off >= 0) begin
      s = abort_off + 1;
      m = (s - 1) / STEP_DIV;
      det = (m + 3) / 4;
      if (det > steps) det = steps;
    end
    @(negedge clk);
    check_eq("ready_idle", qif.cmd_ready, 1'b1);
    qif.cmd_valid = 1'b1;
    qif.cmd_dir   = dir;
    qif.cmd_steps = 16'(steps);
    @(posedge clk);
    #1;
    t0 = cyc;
    qif.cmd_valid = 1'b0;
    for (int i = 1; i <= 4 * det; i++) begin
      ab = dir ? left_tab[i % 4] : right_tab[i % 4];
      exp_q.push_back({32'(t0 + STEP_DIV * i), ab});
    end
    if (steps == 0) begin
      dcyc = t0;
    end else begin
      dcyc = t0 + 4 * STEP_DIV * det + 1;
      if (abort_off >= 0 && t0 + s > dcyc) dcyc = t0 + s;
    end
    exp_pos = dir ? exp_pos - 16'(det) : exp_pos + 16'(det);
    model_det += dir ? -det : det;
    done_q.push_back({32'(dcyc), exp_pos});
    lim = 0;
    while (cyc < dcyc + 3 && lim < 100000) begin
      @(negedge clk);
      lim++;
      qif.cmd_valid = (steps > 0 && cyc == t0 + 1);
      if (qif.cmd_valid) begin
        qif.cmd_dir   = ~dir;
        qif.cmd_steps = 16'd3;
      end
      qif.cmd_abort = (abort_off >= 0 && cyc == t0 + abort_off);
      if (det > 0 && cyc == t0 + 2) begin
        check_eq("run_busy", qif.busy, 1'b1);
        check_eq("run_ready", qif.cmd_ready, 1'b0);
      end
    end
    qif.cmd_valid = 1'b0;
    qif.cmd_abort = 1'b0;
    check_eq("cmd_timeout", lim < 100000, 1'b1);
    check_eq("end_pos", qif.pos, exp_pos);
    check_eq("end_ab", {62'd0, ab_now}, 64'd0);
    check_eq("end_busy", qif.busy, 1'b0);
    check_eq("edges_left", exp_q.size(), 0);
    check_eq("dones_left", done_q.size(), 0);
  endtask

  task automatic reset_mid();
    int t0, lim;
    @(negedge clk);
    qif.cmd_valid = 1'b1;
    qif.cmd_dir   = DIR_RIGHT;
    qif.cmd_steps = 16'd2;
    @(posedge clk);
    #1;
    t0 = cyc;
    qif.cmd_valid = 1'b0;
    exp_q.push_back({32'(t0 + STEP_DIV), 2'b10});
    exp_q.push_back({32'(t0 + 2 * STEP_DIV), 2'b11});
    lim = 0;
    while (cyc < t0 + 2 * STEP_DIV && lim < 1000) begin
      @(negedge clk);
      lim++;
    end
    check_eq("pre_rst_ab", {62'd0, ab_now}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ab", {62'd0, ab_now}, 64'd0);
    check_eq("rst_mid_ready", qif.cmd_ready, 1'b1);
    check_eq("rst_mid_busy", qif.busy, 1'b0);
    check_eq("rst_mid_done", qif.done, 1'b0);
    check_eq("rst_mid_pos", qif.pos, 16'd0);
    exp_pos = '0;
    exp_q.delete();
    done_q.delete();
    exp_w = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_ab", {62'd0, ab_now}, 64'd0);
    check_eq("post_rst_decode", dec_det, model_det);
  endtask

  task automatic w_cmd(input int steps);
    int t0, lim;
    logic seen;
    @(negedge clk);
    qw.cmd_valid = 1'b1;
    qw.cmd_dir   = DIR_RIGHT;
    qw.cmd_steps = 8'(steps);
    @(posedge clk);
    #1;
    t0 = cyc;
    qw.cmd_valid = 1'b0;
    exp_w = exp_w + 8'(steps);
    seen = 1'b0;
    lim = 0;
    while (!seen && lim < 4000) begin
      @(negedge clk);
      lim++;
      if (qw.done) begin
        seen = 1'b1;
        check_eq("w_done_cyc", cyc, t0 + 8 * steps + 1);
        check_eq("w_pos", qw.pos, exp_w);
      end
    end
    check_eq("w_done_seen", seen, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    qif.cmd_valid = 1'b0; qif.cmd_dir = 1'b0; qif.cmd_steps = '0; qif.cmd_abort = 1'b0;
    qw.cmd_valid  = 1'b0; qw.cmd_dir  = 1'b0; qw.cmd_steps  = '0; qw.cmd_abort  = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_ab", {62'd0, ab_now}, 64'd0);
    check_eq("rst_ready", qif.cmd_ready, 1'b1);
    check_eq("rst_busy", qif.busy, 1'b0);
    check_eq("rst_done", qif.done, 1'b0);
    check_eq("rst_pos", qif.pos, 16'd0);
    check_eq("rst_state", dbg_state, IDLE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // abort while idle must have no effect
    @(negedge clk) qif.cmd_abort = 1'b1;
    @(negedge clk) qif.cmd_abort = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_abort_busy", qif.busy, 1'b0);

    run_cmd(DIR_RIGHT, 2, -1);
    run_cmd(DIR_LEFT,  2, -1);
    run_cmd(DIR_LEFT,  1, -1);
    run_cmd(DIR_RIGHT, 0, -1);
    run_cmd(DIR_RIGHT, 1, -1);
    run_cmd(DIR_RIGHT, 5, 2 * STEP_DIV);
    run_cmd(DIR_LEFT,  5, 4 * STEP_DIV - 1);
    run_cmd(DIR_RIGHT, 3, 0);
    run_cmd(DIR_LEFT,  3, STEP_DIV - 1);
    for (int k = 0; k < 3; k++) begin
      run_cmd(logic'($urandom_range(1, 0)), int'($urandom_range(3, 1)), -1);
    end
    reset_mid();
    run_cmd(DIR_RIGHT, 1, -1);
    check_eq("decode_total", dec_det, model_det);

    w_cmd(127);
    w_cmd(1);
    w_cmd(255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/quad_encoder_gen.md
QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 Parameter STEP_DIV, default 50000, SHALL set the clocks between consecutive A/B transitions (legal range 2..2^24-1).
REQ-002 Parameter STEPS_W, default 16, SHALL set the width of the step-count command.
REQ-003 Parameter POS_W, default 16, SHALL set the width of the position counter.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block accepts a command this cycle.
REQ-008 cmd_dir  in  1  0 = right (A leads B), 1 = left (B leads A).
REQ-009 cmd_steps  in  STEPS_W  number of detents to emit.
REQ-010 cmd_abort  in  1  stop at the next detent boundary.
REQ-011 a, b  out  1 each  quadrature outputs, registered.
REQ-012 busy  out  1  a command is in progress.
REQ-013 done  out  1  one-cycle pulse at command completion.
REQ-014 pos  out  POS_W  signed detent position, two's complement.

Function
REQ-015 A command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1; cmd_dir and cmd_steps SHALL be latched then.
REQ-016 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-017 States: IDLE, RUN, DONE; IDLE->RUN on accept with cmd_steps>0; IDLE->DONE on accept with cmd_steps=0; RUN->DONE after last detent; DONE->IDLE after one cycle.
REQ-018 One detent SHALL be four transitions: right {a,b} 00->10->11->01->00; left 00->01->11->10->00.
REQ-019 Exactly one of a/b SHALL change per transition, and a/b SHALL be 00 in IDLE and DONE.
REQ-020 The divider SHALL clear on accept; the first transition SHALL occur STEP_DIV cycles after the accept cycle, each later one STEP_DIV cycles after the previous.
REQ-021 pos SHALL increment (right) or decrement (left) by 1 in the cycle a/b returns to 00; it SHALL wrap modulo 2^POS_W with no saturation.
REQ-022 done SHALL be 1 only in DONE; busy SHALL be 1 in RUN and DONE.
REQ-023 After the 4*cmd_steps-th transition, the next cycle SHALL be DONE.
REQ-024 cmd_abort in RUN at a/b=00 SHALL go to DONE the next cycle with no further transitions.
REQ-025 cmd_abort in RUN mid-detent SHALL complete the current detent at normal pacing and then go to DONE.
REQ-026 cmd_abort outside RUN SHALL be ignored.
REQ-027 cmd_abort coincident with a detent completion SHALL end there, with pos counted once.
REQ-028 The remaining-step counter SHALL be STEPS_W bits wide; cmd_steps = 2^STEPS_W-1 SHALL run fully without wrap.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, a=0, b=0, pos=0, done=0, busy=0, cmd_ready=1, and clear the divider and step counter.
REQ-030 Reset mid-detent SHALL drop a/b to 00 with no completion pulse and no pos update.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/RUN/DONE), the two 4-entry phase tables (right/left) and the direction constants DIR_RIGHT=0 / DIR_LEFT=1.
REQ-032 The STEP_DIV tick generator SHALL be one sub-module, quad_tick_div, with inputs clk, rst_n, clr and output tick.

Verification (bench STEP_DIV=4)
REQ-033 Scenario 1: accept dir=0, steps=2 at cycle 0 -> a/b sequence 10,11,01,00,10,11,01,00 at cycles 4,8,...,32; done at cycle 33; pos=+2.
REQ-034 Scenario 2: dir=1, steps=1 from pos=0 -> a/b sequence 01,11,10,00; pos=-1; done once.
REQ-035 Scenario 3: steps=0 -> done the cycle after accept; a/b stays 00; pos unchanged.
REQ-036 Scenario 4: steps=5 right, abort after the second transition -> detent completes; pos=+1; done; no further edges.
REQ-037 Scenario 5: pos preloaded to 0x7FFF by stepping, then 1 right step -> pos=0x8000.
REQ-038 Scenario 6: rst_n low with a/b=11 -> a/b=00 the same cycle and cmd_ready=1; a bench decoder sees no extra detent.
